pipeline_ctrl: RTL

Parametrised pipeline control unit sitting beside the in-order core pipeline, between the decode stage and the PC/fetch logic. Generates per-stage stall vectors from per-stage stall requests and squashes wrong-path instructions after a branch for a configurable number of bubble cycles. On exceptions or `ertn` it produces a one-cycle flush with a prioritised redirect PC.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_exc_prio_enc.sv | 23 ++
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
// Stage indices, FSM state encoding and exception vector defaults.
package pipeline_ctrl_pkg;

  localparam int STAGE_IF = 0;
  localparam int STAGE_ID = 1;

  localparam logic [31:0] DEF_EXC_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_STRIDE = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHADOW,
    ST_FLUSH
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_exc_prio_enc.sv
// Lowest-index-wins priority encoder for exception requests.
// valid_o is high when any request bit is set.
module exc_prio_enc
  import pipeline_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall vectors, branch shadow squashing and
// one-cycle flush with prioritised redirect PC.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int BRANCH_BUBBLES = 1,
  parameter int NUM_EXC        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_BASE =
    ADDR_WIDTH'(DEF_EXC_BASE),
  parameter logic [ADDR_WIDTH-1:0] EXC_STRIDE =
    ADDR_WIDTH'(DEF_EXC_STRIDE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  id_is_branch_i,
  input  logic [NUM_EXC-1:0]    excepttype_i,
  input  logic                  ertn_i,
  input  logic [ADDR_WIDTH-1:0] epc_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  pc_instr_invalid_o,
  output logic                  if_id_instr_invalid_o,
  output logic                  shadow_busy_o
);

  localparam int CW = $clog2(BRANCH_BUBBLES + 1);
  localparam int IW = idx_w(NUM_EXC);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BRANCH_BUBBLES);

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    flush_q;
  logic [ADDR_WIDTH-1:0]   new_pc_q;

  logic [NUM_STAGES-1:0]   stall_raw;
  logic                    id_stall;
  logic                    exc_vld;
  logic [IW-1:0]           exc_idx;
  logic [ADDR_WIDTH-1:0]   exc_pc;
  logic                    busy;

  exc_prio_enc #(
    .N  (NUM_EXC),
    .IW (IW)
  ) u_enc (
    .req_i   (excepttype_i),
    .valid_o (exc_vld),
    .idx_o   (exc_idx)
  );

  // A stall in stage j must hold every older stage i <= j.
  always_comb begin
    stall_raw = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stall_raw[i] = |(stallreq_i >> i);
    end
  end

  assign id_stall = stall_raw[STAGE_ID];

  assign exc_pc = EXC_BASE
    + (ADDR_WIDTH'(exc_idx) + ADDR_WIDTH'(1))
    * EXC_STRIDE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      unique case (state_q)
        ST_FLUSH: begin
          state_q  <= ST_IDLE;
          cnt_q    <= '0;
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
        default: begin
          if (exc_vld) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= '0;
            flush_q  <= 1'b1;
            new_pc_q <= exc_pc;
          end else if (ertn_i) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= '0;
            flush_q  <= 1'b1;
            new_pc_q <= epc_i;
          end else if (id_is_branch_i && !id_stall) begin
            state_q <= ST_SHADOW;
            cnt_q   <= CNT_LOAD;
          end else if (busy && !id_stall) begin
            cnt_q   <= cnt_q - CW'(1);
            state_q <= (cnt_q == CW'(1)) ? ST_IDLE : ST_SHADOW;
          end
        end
      endcase
    end
  end

  assign busy                  = (cnt_q != '0);
  assign stall_o               = flush_q ? '0 : stall_raw;
  assign flush_o               = flush_q;
  assign new_pc_o              = new_pc_q;
  assign shadow_busy_o         = busy;
  assign pc_instr_invalid_o    = id_is_branch_i & ~flush_q;
  assign if_id_instr_invalid_o = (id_is_branch_i | busy) & ~flush_q;

endmodule
